// File: rtl/deserializador_fifo.sv
// -----------------------------------------------------------------------------
// deserializador_fifo
//   Collects serial bits into WIDTH-bit words, queues the words in a small
//   DEPTH-entry FIFO and presents the head word to a consumer. The consumer
//   uses a level acknowledge, and each ack high pulse pops exactly one word.
//
// Ports
//   clk_100KHz   in   sole clock, rising edge
//   reset        in   asynchronous active-high reset
//   data_in      in   serial data bit
//   write_in     in   data_in valid this cycle
//   ack_in       in   consumer acknowledge (level)
//   clear_in     in   synchronous flush, highest priority
//   data_out     out  head word while data_ready=1, else 0
//   data_ready   out  data_out holds a valid word
//   status_out   out  FIFO full, serial bits are refused
//   count_out    out  FIFO occupancy in words
//   overflow_out out  sticky: a serial bit was refused
// -----------------------------------------------------------------------------
module deserializador_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk_100KHz,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       ack_in,
  input  logic                       clear_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_ready,
  output logic                       status_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       overflow_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_VALID = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_full;
  logic             r_overflow;
  logic [WIDTH-1:0] r_data;
  logic             r_ready;
  state_t           r_state;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_shift_next;
  logic [CW-1:0]    w_count_next;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_load;

  // Bits are refused while full; the registered full flag is the gate.
  assign w_accept = write_in & ~r_full;
  // The word is complete on the edge that accepts its last bit.
  assign w_push   = w_accept & (r_bit_cnt == BW'(WIDTH - 1));

  always_comb begin
    w_shift_next = r_shift;
    if (MSB_FIRST != 0) begin
      w_shift_next = {r_shift[WIDTH-2:0], data_in};
    end else begin
      w_shift_next = {data_in, r_shift[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Output handshake FSM: next state and the pop/load strobes.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (r_count != '0) begin
          w_state_next = ST_VALID;
          w_load       = 1'b1;
        end
      end
      ST_VALID: begin
        if (ack_in) begin
          w_state_next = ST_HOLD;
          w_pop        = 1'b1;
        end
      end
      ST_HOLD: begin
        // Waiting for ack to drop guarantees one pop per ack pulse.
        if (!ack_in) begin
          if (r_count != '0) begin
            w_state_next = ST_VALID;
            w_load       = 1'b1;
          end else begin
            w_state_next = ST_EMPTY;
          end
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else if (clear_in) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Word storage: no reset so the array maps onto RAM; stale contents are
  // never visible because pointers and count are cleared instead.
  always_ff @(posedge clk_100KHz) begin
    if (w_push && !clear_in) begin
      r_mem[r_wr_ptr] <= w_shift_next;
    end
  end

  always_ff @(posedge clk_100KHz or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_data     <= '0;
      r_ready    <= 1'b0;
    end else if (clear_in) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_data     <= '0;
      r_ready    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift   <= w_shift_next;
        r_bit_cnt <= w_push ? '0 : r_bit_cnt + BW'(1);
      end
      if (write_in && r_full) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      // Registered read of the head word.
      if (w_load) begin
        r_data  <= r_mem[r_rd_ptr];
        r_ready <= 1'b1;
      end else if (w_pop) begin
        r_data  <= '0;
        r_ready <= 1'b0;
      end
    end
  end

  assign data_out     = r_data;
  assign data_ready   = r_ready;
  assign status_out   = r_full;
  assign count_out    = r_count;
  assign overflow_out = r_overflow;

endmodule

// File: tb/tb_deserializador_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_deserializador_fifo
//   Drives an MSB-first and an LSB-first instance with the same serial stream.
//   A queue-based model predicts every output; a compare process checks both
//   instances on every falling edge, and directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_deserializador_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic data_in  = 1'b0;
  logic write_in = 1'b0;
  logic ack_in   = 1'b0;
  logic clear_in = 1'b0;

  logic [WIDTH-1:0] d_dout_m, d_dout_l;
  logic             d_ready_m, d_ready_l;
  logic             d_stat_m, d_stat_l;
  logic [CW-1:0]    d_cnt_m, d_cnt_l;
  logic             d_ovf_m, d_ovf_l;

  always #5000 clk = ~clk;

  deserializador_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(1)) u_msb (
    .clk_100KHz(clk), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .clear_in(clear_in), .data_out(d_dout_m),
    .data_ready(d_ready_m), .status_out(d_stat_m), .count_out(d_cnt_m),
    .overflow_out(d_ovf_m)
  );

  deserializador_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MSB_FIRST(0)) u_lsb (
    .clk_100KHz(clk), .reset(reset), .data_in(data_in), .write_in(write_in),
    .ack_in(ack_in), .clear_in(clear_in), .data_out(d_dout_l),
    .data_ready(d_ready_l), .status_out(d_stat_l), .count_out(d_cnt_l),
    .overflow_out(d_ovf_l)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [WIDTH-1:0] msb;
    logic [WIDTH-1:0] lsb;
  } word_t;

  word_t m_q[$];
  bit    m_bits[$];
  bit    m_ready = 1'b0;
  bit    m_hold  = 1'b0;
  bit    m_ovf   = 1'b0;
  word_t m_data  = '0;
  word_t m_new;
  bit    m_was_full;
  bit    m_has_word;

  always @(posedge clk) begin
    if (reset || clear_in) begin
      m_q.delete();
      m_bits.delete();
      m_ready = 1'b0;
      m_hold  = 1'b0;
      m_ovf   = 1'b0;
      m_data  = '0;
    end else begin
      m_was_full = (m_q.size() == DEPTH);
      m_has_word = (m_q.size() != 0);
      // consumer side, decided from the state before this edge
      if (m_hold) begin
        if (!ack_in) begin
          m_hold = 1'b0;
          if (m_has_word) begin
            m_data  = m_q[0];
            m_ready = 1'b1;
          end
        end
      end else if (m_ready) begin
        if (ack_in) begin
          m_q.delete(0);
          m_ready = 1'b0;
          m_hold  = 1'b1;
        end
      end else if (m_has_word) begin
        m_data  = m_q[0];
        m_ready = 1'b1;
      end
      // producer side
      if (write_in) begin
        if (m_was_full) begin
          m_ovf = 1'b1;
        end else begin
          m_bits.push_back(data_in);
          if (m_bits.size() == WIDTH) begin
            m_new = '0;
            for (int i = 0; i < WIDTH; i++) begin
              m_new.msb[WIDTH-1-i] = m_bits[i];
              m_new.lsb[i]         = m_bits[i];
            end
            m_q.push_back(m_new);
            m_bits.delete();
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("cmp_data_msb",  32'(d_dout_m),  32'(m_ready ? m_data.msb : '0));
    check("cmp_data_lsb",  32'(d_dout_l),  32'(m_ready ? m_data.lsb : '0));
    check("cmp_ready_msb", 32'(d_ready_m), 32'(m_ready));
    check("cmp_ready_lsb", 32'(d_ready_l), 32'(m_ready));
    check("cmp_count_msb", 32'(d_cnt_m),   32'(m_q.size()));
    check("cmp_count_lsb", 32'(d_cnt_l),   32'(m_q.size()));
    check("cmp_full_msb",  32'(d_stat_m),  32'(m_q.size() == DEPTH));
    check("cmp_full_lsb",  32'(d_stat_l),  32'(m_q.size() == DEPTH));
    check("cmp_ovf_msb",   32'(d_ovf_m),   32'(m_ovf));
    check("cmp_ovf_lsb",   32'(d_ovf_l),   32'(m_ovf));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit w, input bit d, input bit a, input bit c);
    @(negedge clk);
    #1;
    write_in = w;
    data_in  = d;
    ack_in   = a;
    clear_in = c;
  endtask

  task automatic send_word(input logic [7:0] b, input bit ack_last);
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, b[i], (i == 0) ? ack_last : 1'b0, 1'b0);
    end
  endtask

  task automatic expect_word(input string name, input logic [7:0] exp_msb);
    int waited;
    waited = 0;
    step(0, 0, 0, 0);
    while (!d_ready_m && waited < 5) begin
      step(0, 0, 0, 0);
      waited++;
    end
    check({name, "_ready"}, 32'(d_ready_m), 32'd1);
    check(name, 32'(d_dout_m), 32'(exp_msb));
    $display("word %02h presented, count=%0d", d_dout_m, d_cnt_m);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst_data",  32'(d_dout_m),  32'd0);
    check("rst_ready", 32'(d_ready_m), 32'd0);
    check("rst_full",  32'(d_stat_m),  32'd0);
    check("rst_count", 32'(d_cnt_m),   32'd0);
    check("rst_ovf",   32'(d_ovf_m),   32'd0);
    reset = 1'b0;

    // Bits 1,0,1,1,0,0,1,0 -> B2 (MSB first) / 4D (LSB first)
    send_word(8'hB2, 1'b0);
    step(0, 0, 0, 0);
    check("b2_count_after_push", 32'(d_cnt_m),   32'd1);
    check("b2_ready_after_push", 32'(d_ready_m), 32'd0);
    step(0, 0, 0, 0);
    check("b2_ready",    32'(d_ready_m), 32'd1);
    check("b2_data_msb", 32'(d_dout_m),  32'h0B2);
    check("b2_data_lsb", 32'(d_dout_l),  32'h04D);
    $display("word %02h / %02h presented", d_dout_m, d_dout_l);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("b2_pop_count", 32'(d_cnt_m),   32'd0);
    check("b2_pop_ready", 32'(d_ready_m), 32'd0);
    check("b2_pop_data",  32'(d_dout_m),  32'd0);
    step(0, 0, 0, 0);

    // Fill to full, then a refused fifth word
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    send_word(8'h44, 1'b0);
    send_word(8'h55, 1'b0);
    step(0, 0, 0, 0);
    check("full_status", 32'(d_stat_m),  32'd1);
    check("full_count",  32'(d_cnt_m),   32'd4);
    check("full_ovf",    32'(d_ovf_m),   32'd1);
    check("full_head",   32'(d_dout_m),  32'h011);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("full_pop_count",  32'(d_cnt_m),  32'd3);
    check("full_pop_status", 32'(d_stat_m), 32'd0);
    step(0, 0, 0, 0);
    check("next_head_22", 32'(d_dout_m), 32'h022);

    // Long ack: exactly one pop
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("long_ack_count", 32'(d_cnt_m),   32'd2);
    check("long_ack_ready", 32'(d_ready_m), 32'd0);
    step(0, 0, 0, 0);
    check("long_ack_ready2", 32'(d_ready_m), 32'd1);
    check("long_ack_head",   32'(d_dout_m),  32'h033);

    // Push and pop on the same edge
    send_word(8'h66, 1'b1);
    step(0, 0, 0, 0);
    check("pushpop_count", 32'(d_cnt_m), 32'd2);
    expect_word("order_44", 8'h44);
    expect_word("order_66", 8'h66);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("drained_count", 32'(d_cnt_m), 32'd0);

    // Reset in the middle of a word
    send_word(8'h77, 1'b0);
    for (int i = 0; i < 5; i++) step(1, 1'b1, 0, 0);
    @(negedge clk);
    #1;
    reset    = 1'b1;
    write_in = 1'b0;
    #1;
    check("async_rst_data",  32'(d_dout_m),  32'd0);
    check("async_rst_ready", 32'(d_ready_m), 32'd0);
    check("async_rst_count", 32'(d_cnt_m),   32'd0);
    check("async_rst_ovf",   32'(d_ovf_m),   32'd0);
    step(0, 0, 0, 0);
    reset = 1'b0;
    send_word(8'hFF, 1'b0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("ff_data_msb", 32'(d_dout_m), 32'h0FF);
    check("ff_data_lsb", 32'(d_dout_l), 32'h0FF);
    check("ff_count",    32'(d_cnt_m),  32'd1);
    $display("word %02h presented after reset", d_dout_m);

    // Clear while in HOLD
    send_word(8'h3C, 1'b0);
    step(0, 0, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    check("hold_count",  32'(d_cnt_m),   32'd1);
    check("hold_ready",  32'(d_ready_m), 32'd0);
    step(0, 0, 0, 0);
    check("clr_count", 32'(d_cnt_m),   32'd0);
    check("clr_ready", 32'(d_ready_m), 32'd0);
    check("clr_data",  32'(d_dout_m),  32'd0);
    check("clr_full",  32'(d_stat_m),  32'd0);
    check("clr_ovf",   32'(d_ovf_m),   32'd0);
    send_word(8'h5A, 1'b0);
    step(0, 0, 0, 0);
    check("post_clr_ready0", 32'(d_ready_m), 32'd0);
    step(0, 0, 0, 0);
    check("post_clr_ready1", 32'(d_ready_m), 32'd1);
    check("post_clr_data",   32'(d_dout_m),  32'h05A);
    check("post_clr_lsb",    32'(d_dout_l),  32'h05A);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deserializador_fifo.md
DESERIALIZADOR_FIFO -- requirements
Module: deserializador_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per assembled word (legal range 2..32).
REQ-002 SHALL have parameter DEPTH, default 4, word-FIFO depth (power of 2, legal range 2..16).
REQ-003 SHALL have parameter MSB_FIRST, default 1; 1 = first serial bit lands in data_out[WIDTH-1], 0 = first serial bit lands in data_out[0].
REQ-004 SHALL have port clk_100KHz  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_in  input  1  serial data bit.
REQ-007 SHALL have port write_in  input  1  data_in is valid this cycle.
REQ-008 SHALL have port ack_in  input  1  consumer acknowledge, level signal.
REQ-009 SHALL have port clear_in  input  1  synchronous flush.
REQ-010 SHALL have port data_out  output  WIDTH  head word while data_ready=1, else 0.
REQ-011 SHALL have port data_ready  output  1  data_out holds a valid word.
REQ-012 SHALL have port status_out  output  1  FIFO full; serial bits are refused.
REQ-013 SHALL have port count_out  output  $clog2(DEPTH+1)  FIFO occupancy in words.
REQ-014 SHALL have port overflow_out  output  1  sticky flag: a bit was refused.

Function
REQ-015 SHALL accept a bit on an edge where write_in=1 and status_out=0; the bit counter increments mod WIDTH.
REQ-016 SHALL write the assembled word into the FIFO tail on the edge that accepts the WIDTH-th bit, with count_out incremented on that edge and the bit counter returned to 0.
REQ-017 SHALL order bits per MSB_FIRST: shift-left insertion at bit 0 when 1, shift-right insertion at bit WIDTH-1 when 0.
REQ-018 SHALL ignore write_in=1 while status_out=1, leave the shift register and bit counter unchanged, and set overflow_out on that edge.
REQ-019 SHALL continue accumulating a partial word while the FIFO is not full, even if the consumer is stalled.
REQ-020 SHALL drive status_out = (count_out == DEPTH), registered and updated on the same edge as count_out.
REQ-021 SHALL implement output FSM states EMPTY, VALID, HOLD.
REQ-022 SHALL move EMPTY -> VALID on an edge where count_out != 0, registering the head word into data_out and setting data_ready=1.
REQ-023 SHALL pop the head word on the edge where the FSM is in VALID and ack_in=1, then enter HOLD with data_ready=0 and data_out=0.
REQ-024 SHALL remain in HOLD while ack_in=1; on ack_in=0, go to VALID, loading the new head, if the post-pop count != 0, else go to EMPTY.
REQ-025 SHALL pop at most one word per ack_in high pulse, whatever its length.
REQ-026 SHALL perform both operations on an edge that has a push and a pop, leaving count_out unchanged; pointers wrap modulo DEPTH.
REQ-027 SHALL give a latency of one edge from a word's push to data_ready=1: last bit accepted at edge k, data_ready=1 after edge k+1 if the FIFO was empty and the FSM was in EMPTY.
REQ-028 SHALL give clear_in=1 priority over write_in and ack_in: clear FIFO, pointers, bit counter, shift register and overflow_out, force EMPTY, and drive outputs to their reset values on that edge.

Reset
REQ-029 SHALL, on reset=1 and without waiting for a clock edge, drive data_out=0, data_ready=0, status_out=0, count_out=0 and overflow_out=0, clear the shift register, bit counter and pointers, and set FSM=EMPTY.
REQ-030 SHALL, on reset mid-word or mid-handshake, discard all partial and stored data; the first accepted bit after release starts a new word.

Verification
REQ-031 SHALL cover: WIDTH=8, MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 -> data_out=8'hB2 and data_ready=1 one edge after the 8th bit.
REQ-032 SHALL cover: MSB_FIRST=0, same bits -> data_out=8'h4D.
REQ-033 SHALL cover: 5 words with no ack at DEPTH=4 -> status_out=1, count_out=4, 5th word's bits refused, overflow_out=1; the first ack returns word 1.
REQ-034 SHALL cover: ack_in held high 10 cycles with 3 words stored -> exactly one pop, count_out=2; after ack_in low, data_ready=1 with word 2.
REQ-035 SHALL cover: push-completing bit and ack pop on the same edge with count_out=2 -> count_out stays 2 and word order is preserved.
REQ-036 SHALL cover: reset asserted after 5 of 8 bits, then 8 new bits 0xFF -> data_out=8'hFF with no residue; clear_in mid-HOLD -> all outputs 0, FSM in EMPTY.
